// File: rtl/wb_irq_ctrl_if.sv
// Wishbone B3 classic slave bus bundle for wb_irq_ctrl.
// Ports:
//   wb_adr_i[4:0], wb_dat_i[31:0], wb_sel_i[3:0], wb_we_i, wb_cyc_i, wb_stb_i : master -> slave
//   wb_dat_o[31:0], wb_ack_o, wb_err_o                                        : slave -> master
interface wb_irq_ctrl_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_irq_ctrl.sv
// Wishbone B3 interrupt controller: per-channel sync, level/edge, polarity,
// mask and W1C pending, driving the 32-bit CPU irq vector.
// Ports:
//   wb_clk_i, wb_rst_n_i : clock, async active-low reset
//   wb                   : Wishbone slave bus (wb_irq_ctrl_if.slave)
//   irq_src_i            : raw interrupt sources (may be asynchronous)
//   irq_o                : registered PEND & MASK
//   irq_any_o            : registered OR of PEND & MASK
module wb_irq_ctrl #(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'h0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  wb_irq_ctrl_if.slave       wb,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  output logic [31:0]        irq_o,
  output logic               irq_any_o
);

  localparam logic [31:0] IMPL = 32'((64'd1 << NUM_IRQ) - 64'd1);
  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_EDGE  = 3'd2;
  localparam logic [2:0] REG_POL   = 3'd3;
  localparam logic [2:0] REG_MPEND = 3'd4;
  localparam logic [2:0] REG_SET   = 3'd5;

  logic [31:0] r_mask, r_edge, r_pol, r_pend, r_prev, r_squash;
  logic [31:0] r_irq, r_dat;
  logic        r_any, r_ack, r_err;

  logic [31:0] w_src, w_s, w_a, w_rise;
  logic [31:0] w_bmask, w_wdat, w_rdata;
  logic [31:0] w_mask_nx, w_edge_nx, w_pol_nx, w_pend_nx, w_chg, w_w1c, w_setw;
  logic [2:0]  w_reg;
  logic        w_acc, w_unmapped, w_wr;
  logic        w_unused;

  assign w_src    = 32'(irq_src_i);
  assign w_unused = ^wb.wb_adr_i[1:0];

  // Source synchroniser chain (bypassed when inputs are already synchronous)
  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = w_src & IMPL;
  end else begin : g_sync
    logic [31:0] r_sync [SYNC_STAGES];
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        for (int k = 0; k < int'(SYNC_STAGES); k++) r_sync[k] <= '0;
      end else begin
        r_sync[0] <= w_src;
        for (int k = 1; k < int'(SYNC_STAGES); k++) r_sync[k] <= r_sync[k-1];
      end
    end
    assign w_s = r_sync[SYNC_STAGES-1] & IMPL;
  end

  // Bus decode
  assign w_reg      = wb.wb_adr_i[4:2];
  assign w_unmapped = (w_reg >= 3'd6);
  assign w_acc      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
  assign w_wr       = w_acc & wb.wb_we_i & ~w_unmapped;
  assign w_bmask    = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                       {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}} & IMPL;
  assign w_wdat     = wb.wb_dat_i & w_bmask;

  // Polarity-adjusted source; edge detect is suppressed for one cycle on
  // channels whose EDGE/POL just changed so prev can reload cleanly.
  assign w_a    = w_s ^ r_pol;
  assign w_rise = w_a & ~r_prev & ~r_squash;

  // Register write next-state and pending update
  always_comb begin
    w_mask_nx = r_mask;
    w_edge_nx = r_edge;
    w_pol_nx  = r_pol;
    w_w1c     = '0;
    w_setw    = '0;
    if (w_wr) begin
      case (w_reg)
        REG_PEND: w_w1c     = w_wdat;
        REG_MASK: w_mask_nx = (r_mask & ~w_bmask) | w_wdat;
        REG_EDGE: w_edge_nx = (r_edge & ~w_bmask) | w_wdat;
        REG_POL:  w_pol_nx  = (r_pol  & ~w_bmask) | w_wdat;
        REG_SET:  w_setw    = w_wdat;
        default:  ;
      endcase
    end
    w_chg = (w_edge_nx ^ r_edge) | (w_pol_nx ^ r_pol);
    // Edge: set (rise or SET) wins over W1C; level: follows a directly
    w_pend_nx = ((r_edge & ((r_pend & ~w_w1c) | w_rise | w_setw)) |
                 (~r_edge & w_a)) & ~w_chg & IMPL;
  end

  // Read mux
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_PEND:  w_rdata = r_pend;
      REG_MASK:  w_rdata = r_mask;
      REG_EDGE:  w_rdata = r_edge;
      REG_POL:   w_rdata = r_pol;
      REG_MPEND: w_rdata = r_pend & r_mask;
      default:   w_rdata = '0;
    endcase
  end

  // State, bus response and interrupt outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_mask   <= RESET_MASK & IMPL;
      r_edge   <= '0;
      r_pol    <= '0;
      r_pend   <= '0;
      r_prev   <= '0;
      r_squash <= '0;
      r_irq    <= '0;
      r_any    <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_mask   <= w_mask_nx;
      r_edge   <= w_edge_nx;
      r_pol    <= w_pol_nx;
      r_pend   <= w_pend_nx;
      r_prev   <= w_a;
      r_squash <= w_chg;
      r_irq    <= r_pend & r_mask;
      r_any    <= |(r_pend & r_mask);
      r_ack    <= w_acc & ~w_unmapped;
      r_err    <= w_acc & w_unmapped;
      r_dat    <= (w_acc && !w_unmapped) ? w_rdata : '0;
    end
  end

  assign wb.wb_dat_o = r_dat;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign irq_o       = r_irq;
  assign irq_any_o   = r_any;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed self-checking bench for wb_irq_ctrl (32-channel and 8-channel instances).
module tb_wb_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  t_adr;
  logic [31:0] t_dat;
  logic [3:0]  t_sel;
  logic        t_we, t_cyc, t_stb, t_dsel;
  logic [31:0] t_src0;
  logic [7:0]  t_src1;
  logic [31:0] irq0, irq1;
  logic        any0, any1;
  logic [31:0] m_dat;
  logic        m_ack, m_err;
  int          checks = 0;
  int          errors = 0;

  wb_irq_ctrl_if bus0();
  wb_irq_ctrl_if bus1();

  assign bus0.wb_adr_i = t_adr;
  assign bus0.wb_dat_i = t_dat;
  assign bus0.wb_sel_i = t_sel;
  assign bus0.wb_we_i  = t_we;
  assign bus0.wb_cyc_i = t_cyc & ~t_dsel;
  assign bus0.wb_stb_i = t_stb & ~t_dsel;
  assign bus1.wb_adr_i = t_adr;
  assign bus1.wb_dat_i = t_dat;
  assign bus1.wb_sel_i = t_sel;
  assign bus1.wb_we_i  = t_we;
  assign bus1.wb_cyc_i = t_cyc & t_dsel;
  assign bus1.wb_stb_i = t_stb & t_dsel;

  assign m_dat = t_dsel ? bus1.wb_dat_o : bus0.wb_dat_o;
  assign m_ack = t_dsel ? bus1.wb_ack_o : bus0.wb_ack_o;
  assign m_err = t_dsel ? bus1.wb_err_o : bus0.wb_err_o;

  wb_irq_ctrl #(.NUM_IRQ(32), .SYNC_STAGES(2), .RESET_MASK(32'h0)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(bus0),
    .irq_src_i(t_src0), .irq_o(irq0), .irq_any_o(any0)
  );

  wb_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2), .RESET_MASK(32'hFFFF_FFFF)) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(bus1),
    .irq_src_i(t_src1), .irq_o(irq1), .irq_any_o(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access; waits at most 4 cycles for ack/err
  task automatic xfer(input logic d, input logic we, input logic [4:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rd, output logic ack, output logic err);
    t_dsel = d; t_adr = adr; t_dat = dat; t_sel = sel; t_we = we;
    t_cyc = 1'b1; t_stb = 1'b1;
    rd = '0; ack = 1'b0; err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (m_ack || m_err) begin
        rd = m_dat; ack = m_ack; err = m_err;
        break;
      end
    end
    t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
  endtask

  task automatic wr(input logic d, input logic [4:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] rd;
    logic        a, e;
    xfer(d, 1'b1, adr, dat, sel, rd, a, e);
    chk("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic rdchk(input string tag, input logic d, input logic [4:0] adr,
                       input logic [31:0] exp);
    logic [31:0] rd;
    logic        a, e;
    xfer(d, 1'b0, adr, 32'h0, 4'hF, rd, a, e);
    chk({tag, "_ack"}, 32'(a), 32'd1);
    chk(tag, rd, exp);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] rd;
    logic        a, e;
    rst_n = 1'b0;
    t_adr = '0; t_dat = '0; t_sel = '0; t_we = 1'b0;
    t_cyc = 1'b0; t_stb = 1'b0; t_dsel = 1'b0;
    t_src0 = '0; t_src1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc_wait(2);

    // Reset asserted mid-transfer
    t_dsel = 1'b0; t_adr = 5'h04; t_dat = 32'hFFFF_FFFF; t_sel = 4'hF; t_we = 1'b1;
    t_cyc = 1'b1; t_stb = 1'b1;
    #2 rst_n = 1'b0;
    cyc_wait(1);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_dat", m_dat, 32'h0);
    chk("rst_irq", irq0, 32'h0);
    chk("rst_any", 32'(any0), 32'd0);
    cyc_wait(1);
    t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
    rst_n = 1'b1;
    cyc_wait(1);
    chk("rst_stray_ack", 32'(m_ack), 32'd0);
    rdchk("rst_pend",  1'b0, 5'h00, 32'h0);
    rdchk("rst_mask",  1'b0, 5'h04, 32'h0);
    rdchk("rst_edge",  1'b0, 5'h08, 32'h0);
    rdchk("rst_pol",   1'b0, 5'h0C, 32'h0);
    rdchk("rst_mpend", 1'b0, 5'h10, 32'h0);
    rdchk("rst_mask8", 1'b1, 5'h04, 32'h0000_00FF);

    // Level channel 2
    wr(1'b0, 5'h04, 32'h4, 4'hF);
    t_src0[2] = 1'b1;
    cyc_wait(3);
    chk("lvl_irq_early", irq0, 32'h0);
    cyc_wait(1);
    chk("lvl_irq", irq0, 32'h4);
    chk("lvl_any", 32'(any0), 32'd1);
    wr(1'b0, 5'h00, 32'h4, 4'hF);
    cyc_wait(1);
    chk("lvl_w1c_ignored", irq0, 32'h4);
    rdchk("lvl_pend", 1'b0, 5'h00, 32'h4);
    t_src0[2] = 1'b0;
    cyc_wait(3);
    chk("lvl_drop_early", irq0, 32'h4);
    cyc_wait(1);
    chk("lvl_drop", irq0, 32'h0);

    // Edge channel 0 with W1C
    wr(1'b0, 5'h08, 32'h1, 4'hF);
    wr(1'b0, 5'h04, 32'h1, 4'hF);
    t_src0[0] = 1'b1;
    cyc_wait(3);
    t_src0[0] = 1'b0;
    cyc_wait(4);
    chk("edge_irq", irq0, 32'h1);
    rdchk("edge_pend", 1'b0, 5'h00, 32'h1);
    wr(1'b0, 5'h00, 32'h1, 4'hF);
    chk("edge_irq_at_ack", irq0, 32'h1);
    cyc_wait(1);
    chk("edge_irq_cleared", irq0, 32'h0);

    // Rising edge lands on the same cycle as a W1C: set wins
    cyc_wait(1);
    t_src0[0] = 1'b1;
    cyc_wait(2);
    wr(1'b0, 5'h00, 32'h1, 4'hF);
    rdchk("edge_set_wins", 1'b0, 5'h00, 32'h1);
    t_src0[0] = 1'b0;
    cyc_wait(4);
    wr(1'b0, 5'h00, 32'h1, 4'hF);
    rdchk("edge_recleared", 1'b0, 5'h00, 32'h0);

    // Polarity on edge channel 1
    wr(1'b0, 5'h08, 32'h2, 4'hF);
    wr(1'b0, 5'h0C, 32'h2, 4'hF);
    cyc_wait(4);
    rdchk("pol_flip_no_pend", 1'b0, 5'h00, 32'h0);
    t_src0[1] = 1'b1;
    cyc_wait(5);
    rdchk("pol_rise_no_pend", 1'b0, 5'h00, 32'h0);
    t_src0[1] = 1'b0;
    cyc_wait(5);
    rdchk("pol_fall_pend", 1'b0, 5'h00, 32'h2);
    chk("pol_masked_irq", irq0, 32'h0);
    wr(1'b0, 5'h00, 32'h2, 4'hF);
    wr(1'b0, 5'h0C, 32'h0, 4'hF);
    cyc_wait(4);
    rdchk("pol_restore", 1'b0, 5'h00, 32'h0);

    // Bus: unmapped access and byte lanes
    xfer(1'b0, 1'b0, 5'h18, 32'h0, 4'hF, rd, a, e);
    chk("unmap_err", 32'(e), 32'd1);
    chk("unmap_ack", 32'(a), 32'd0);
    cyc_wait(1);
    chk("unmap_err_1cyc", 32'(m_err), 32'd0);
    wr(1'b0, 5'h04, 32'h0, 4'hF);
    wr(1'b0, 5'h04, 32'hFFFF_FFFF, 4'b0010);
    rdchk("sel_mask", 1'b0, 5'h04, 32'h0000_FF00);

    // SET on edge channel 7, then on level channel 2
    wr(1'b0, 5'h08, 32'h80, 4'hF);
    wr(1'b0, 5'h04, 32'h80, 4'hF);
    wr(1'b0, 5'h14, 32'h80, 4'hF);
    cyc_wait(1);
    chk("set_irq", irq0, 32'h80);
    chk("set_any", 32'(any0), 32'd1);
    rdchk("set_pend",  1'b0, 5'h00, 32'h80);
    rdchk("set_mpend", 1'b0, 5'h10, 32'h80);
    rdchk("set_reads0", 1'b0, 5'h14, 32'h0);
    wr(1'b0, 5'h14, 32'h4, 4'hF);
    rdchk("set_level_ignored", 1'b0, 5'h00, 32'h80);

    // Narrow instance: unimplemented bits stay 0
    t_src1 = 8'hFF;
    cyc_wait(4);
    chk("n8_irq", irq1, 32'h0000_00FF);
    chk("n8_any", 32'(any1), 32'd1);
    wr(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF);
    rdchk("n8_mask", 1'b1, 5'h04, 32'h0000_00FF);
    rdchk("n8_pend", 1'b1, 5'h00, 32'h0000_00FF);
    wr(1'b1, 5'h04, 32'h0, 4'hF);
    rdchk("n8_mask0", 1'b1, 5'h04, 32'h0);
    cyc_wait(1);
    chk("n8_irq_masked", irq1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
